// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative mantissa ALU: FSM states, operation
// encodings and the width helper for the shift-add step counter.
package iter_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Bits needed to count 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/iter_mantissa_alu_dp.sv
// Shift-and-add multiplier datapath: one multiplier bit is consumed per step.
// Macro ITER_MANTISSA_ALU_EARLY_EXIT_EN: when defined, the last step is also
// flagged as soon as the remaining multiplier bits are all zero.
module iter_mantissa_alu_dp
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 last
);

    localparam int CW = count_width(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mplier_next;
    logic [CW-1:0]      count_next;

    // Values the registers take on the current step; acc_next also feeds the result.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mplier_next = mplier >> 1;
        count_next  = count + CW'(1);
    end

`ifdef ITER_MANTISSA_ALU_EARLY_EXIT_EN
    assign last = (count_next == CW'(WIDTH)) || (mplier_next == '0);
`else
    assign last = (count_next == CW'(WIDTH));
`endif

    // Register update: reset clears, load seeds a new product, step advances one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mcand_in};
            mplier <= mplier_in;
            count  <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            count  <= count_next;
        end
    end

endmodule

// File: rtl/iter_mantissa_alu.sv
// Iterative mantissa ALU: single-cycle add, shift-and-add multiply with
// shortcuts for zero and unit multipliers.
// Macro ITER_MANTISSA_ALU_EARLY_EXIT_EN (handled in the datapath) ends a
// multiply once no multiplier bits remain; results are identical either way.
//
// Handshake: start is sampled only while busy is low; an accepted start raises
// busy on the next cycle, busy stays high through the single-cycle done pulse,
// and result is valid from the done cycle until the next operation completes.
module iter_mantissa_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sum_or_mul,
    input  logic [WIDTH-1:0]     valor1,
    input  logic [WIDTH-1:0]     valor2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    state_t             state;
    logic               op_add;
    logic               zero_op;
    logic               unit_op;
    logic               dp_load;
    logic               dp_step;
    logic               dp_last;
    logic [2*WIDTH-1:0] dp_acc_next;

    // Shortcut detection and datapath control for the operation at the input.
    always_comb begin
        op_add  = (sum_or_mul == OP_ADD);
        zero_op = (valor1 == '0) || (valor2 == '0);
        unit_op = (valor2 == WIDTH'(1));
        dp_load = (state == IDLE) && start && !op_add && !zero_op && !unit_op;
        dp_step = (state == MUL);
    end

    iter_mantissa_alu_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (dp_load),
        .step      (dp_step),
        .mcand_in  (valor1),
        .mplier_in (valor2),
        .acc_next  (dp_acc_next),
        .last      (dp_last)
    );

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (op_add) begin
                            result <= (2*WIDTH)'(valor1) + (2*WIDTH)'(valor2);
                            state  <= DONE;
                            done   <= 1'b1;
                        end else if (zero_op) begin
                            result <= '0;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else if (unit_op) begin
                            result <= (2*WIDTH)'(valor1);
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (dp_last) begin
                        result <= dp_acc_next;
                        state  <= DONE;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/iter_mantissa_alu.md
ITER_MANTISSA_ALU -- requirements
Module: iter_mantissa_alu

Interface
REQ-001 Parameter: WIDTH, default 24, operand (mantissa) width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request pulse; sampled only when busy is low.
REQ-005 Port: sum_or_mul  input  1  operation select: 0 = multiply, 1 = add.
REQ-006 Port: valor1  input  WIDTH  operand A (multiplicand / addend).
REQ-007 Port: valor2  input  WIDTH  operand B (multiplier / addend).
REQ-008 Port: busy  output  1  high from accepted start until the done cycle inclusive.
REQ-009 Port: done  output  1  one-cycle pulse marking result valid.
REQ-010 Port: result  output  2*WIDTH  registered result; held until the next accepted start completes.

Function
REQ-011 The FSM SHALL have states IDLE, MUL, DONE; busy = (state != IDLE).
REQ-012 In IDLE, start=1 at edge k SHALL latch valor1, valor2 and sum_or_mul; start SHALL be ignored in MUL and DONE.
REQ-013 Add: at edge k, result SHALL load zero-extended valor1+valor2 (carry in bit WIDTH); state -> DONE; done high in cycle k+1.
REQ-014 Multiply, valor1==0 or valor2==0: at edge k, result SHALL load 0; state -> DONE.
REQ-015 Multiply, valor2==1 (and valor1!=0): at edge k, result SHALL load zero-extended valor1; state -> DONE.
REQ-016 Multiply, otherwise: at edge k, load acc=0, mcand=zero-extended valor1 (2*WIDTH), mplier=valor2, count=0; state -> MUL.
REQ-017 Each MUL edge SHALL do: if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1; count+=1 (shift-and-add, one multiplier bit per cycle).
REQ-018 MUL SHALL exit to DONE, loading result with the updated acc, on the edge where count reaches WIDTH (subject to REQ-025).
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start during DONE is ignored.
REQ-020 Product SHALL be exact: result = valor1*valor2 over 2*WIDTH bits, no truncation or rounding.
REQ-021 result SHALL remain stable from its load until the next load; input changes after acceptance SHALL have no effect.

Reset
REQ-022 reset=1 at any edge SHALL force state IDLE, busy=0, done=0, result=0, and clear acc, mcand, mplier, count.
REQ-023 Reset during MUL or DONE SHALL abort the operation with no done pulse; reset SHALL take priority over start.

Configuration
REQ-024 Macro ITER_MANTISSA_ALU_EARLY_EXIT_EN selects multiply termination.
REQ-025 Defined: MUL SHALL also exit on the edge where the updated mplier is zero, so MUL lasts (index of MSB set in valor2)+1 cycles; undefined: MUL SHALL always last exactly WIDTH cycles. result values SHALL be identical in both builds.

Structure
REQ-026 Package iter_alu_pkg SHALL hold the state enum (IDLE, MUL, DONE), op encodings (OP_MUL=0, OP_ADD=1), and a count-width function clog2(WIDTH+1).
REQ-027 The shift-add datapath (acc, mcand, mplier, count registers and adder) SHALL be a sub-module iter_mantissa_alu_dp; the FSM and shortcut detection stay in the top.

Verification (WIDTH=24)
REQ-028 Add: valor1=0xFFFFFF, valor2=0x000001, start -> done 1 cycle later, result=0x000001000000.
REQ-029 Multiply: valor1=0x800000, valor2=0xC00000 -> result=0x600000000000; done 25 cycles after start edge in both builds (MSB index 23).
REQ-030 Multiply: valor1=0x000123, valor2=0x000005 -> result=0x0005AF; done after 25 cycles without macro, 4 cycles with macro.
REQ-031 Shortcuts: valor1=0 or valor2=0 -> result=0, done 1 cycle later; valor2=1, valor1=0xABCDEF -> result=0x000000ABCDEF, done 1 cycle later.
REQ-032 Protocol: start held high through a multiply -> exactly one done, no re-accept until IDLE; reset asserted at MUL cycle 10 -> no done, busy=0 and result=0 next cycle, new start accepted immediately after.
